// File: rtl/alu_seq_hs.sv
// Handshaked sequential ALU: single-cycle arithmetic/logic ops and an iterative
// one-bit-per-cycle shifter, with the result and flags held until consumed.
module alu_seq_hs #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] s_amt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               flag_z,
  output logic               flag_n,
  output logic               flag_c,
  output logic               flag_v,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_reg;
  logic [2:0]         op_reg;
  logic [SHAMT_W-1:0] cnt_reg;

  logic               is_shift;
  logic               is_arith;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [WIDTH-1:0]   shift_next;
  logic               shift_out;

  assign in_ready = (state_reg == IDLE) && !rst;
  assign busy     = (state_reg != IDLE);

  // SUB reuses the adder as a + ~b + 1 so carry-out doubles as the no-borrow flag
  always_comb begin
    is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == 3'b111);
    is_arith = (op == OP_ADD) || (op == OP_SUB);
    b_eff    = (op == OP_SUB) ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op == OP_SUB)};
    case (op)
      OP_ADD, OP_SUB: alu_res = sum[WIDTH-1:0];
      OP_AND:         alu_res = a & b;
      OP_OR:          alu_res = a | b;
      OP_XOR:         alu_res = a ^ b;
      default:        alu_res = a;
    endcase
    alu_c = is_arith && sum[WIDTH];
    alu_v = is_arith && (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

  // The result register is the shifter's working register while in SHIFT
  always_comb begin
    case (op_reg)
      OP_SLL: begin
        shift_next = {result[WIDTH-2:0], 1'b0};
        shift_out  = result[WIDTH-1];
      end
      OP_SRL: begin
        shift_next = {1'b0, result[WIDTH-1:1]};
        shift_out  = result[0];
      end
      default: begin
        shift_next = {result[WIDTH-1], result[WIDTH-1:1]};
        shift_out  = result[0];
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      op_reg    <= 3'b000;
      cnt_reg   <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            op_reg <= op;
            if (is_shift) begin
              result <= a;
              flag_z <= (a == '0);
              flag_n <= a[WIDTH-1];
              flag_c <= 1'b0;
              flag_v <= 1'b0;
              cnt_reg <= s_amt;
              if (s_amt == '0) begin
                state_reg <= DONE;
                out_valid <= 1'b1;
              end else begin
                state_reg <= SHIFT;
              end
            end else begin
              result    <= alu_res;
              flag_z    <= (alu_res == '0);
              flag_n    <= alu_res[WIDTH-1];
              flag_c    <= alu_c;
              flag_v    <= alu_v;
              state_reg <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          result  <= shift_next;
          flag_c  <= shift_out;
          flag_z  <= (shift_next == '0);
          flag_n  <= shift_next[WIDTH-1];
          cnt_reg <= cnt_reg - SHAMT_W'(1);
          if (cnt_reg == SHAMT_W'(1)) begin
            state_reg <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
            out_valid <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_hs.sv
// Self-checking bench for alu_seq_hs: scoreboard of expected {result,Z,N,C,V},
// latency/handshake checks, mid-op reset and op_count wrap on a CNT_W=4 copy.
module tb_alu_seq_hs;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_ready;
  logic [2:0] op = 3'b000;
  logic [7:0] a = 8'h00, b = 8'h00;
  logic [2:0] s_amt = 3'd0;
  logic       out_valid, out_ready = 1'b0;
  logic [7:0] result;
  logic       flag_z, flag_n, flag_c, flag_v, busy;
  logic [7:0] op_count;

  logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0;
  logic [7:0] result4;
  logic       z4, n4, c4, v4, busy4;
  logic [3:0] op_count4;

  int total = 0;
  int bad = 0;
  logic [11:0] sb[$];

  always #5 clk = ~clk;

  alu_seq_hs #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .s_amt(s_amt), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .flag_v(flag_v), .busy(busy), .op_count(op_count)
  );

  alu_seq_hs #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .op(op),
    .a(a), .b(b), .s_amt(s_amt), .out_valid(out_valid4), .out_ready(out_ready4),
    .result(result4), .flag_z(z4), .flag_n(n4), .flag_c(c4),
    .flag_v(v4), .busy(busy4), .op_count(op_count4)
  );

  // Reference model: {result, Z, N, C, V}
  function automatic logic [11:0] model(input logic [2:0] o, input logic [7:0] x,
                                        input logic [7:0] y, input logic [2:0] s);
    logic [8:0] w;
    logic [7:0] r;
    logic       c, v;
    int         k;
    c = 1'b0; v = 1'b0; k = int'(s); r = 8'h00; w = 9'h000;
    case (o)
      3'd0: begin
        w = {1'b0, x} + {1'b0, y}; r = w[7:0]; c = w[8];
        v = (x[7] == y[7]) && (r[7] != x[7]);
      end
      3'd1: begin
        r = x - y; c = (x >= y);
        v = (x[7] != y[7]) && (r[7] != x[7]);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: begin r = x << k; c = (k == 0) ? 1'b0 : x[8-k]; end
      3'd6: begin r = x >> k; c = (k == 0) ? 1'b0 : x[k-1]; end
      default: begin r = 8'($signed(x) >>> k); c = (k == 0) ? 1'b0 : x[k-1]; end
    endcase
    return {r, (r == 8'h00), r[7], c, v};
  endfunction

  task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                      input logic [2:0] s);
    op = o; a = x; b = y; s_amt = s; in_valid = 1'b1;
    sb.push_back(model(o, x, y, s));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out_valid, result, flag_z, flag_n, flag_c, flag_v, busy, op_count, in_ready} !== 23'h0) begin
      bad++;
      $display("FAIL reset_state got ov=%b res=%h flags=%b%b%b%b busy=%b cnt=%0d rdy=%b want all 0",
               out_valid, result, flag_z, flag_n, flag_c, flag_v, busy, op_count, in_ready);
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL ready_after_reset got=%b want=1", in_ready);
    end
  endtask

  task automatic test_add;
    int lat;
    logic [11:0] e;
    send(3'd0, 8'h7F, 8'h01, 3'd0);
    wait_out(lat);
    e = sb.pop_front();
    $display("txn ADD 7f+01 lat=%0d res=%h zncv=%b%b%b%b", lat, result, flag_z, flag_n, flag_c, flag_v);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL add_latency got=%0d want=1", lat); end
    total++;
    if ({result, flag_z, flag_n, flag_c, flag_v} !== {8'h80, 4'b0101}) begin
      bad++; $display("FAIL add_overflow got=%h want=%h", {result, flag_z, flag_n, flag_c, flag_v}, {8'h80, 4'b0101});
    end
    total++;
    if ({result, flag_z, flag_n, flag_c, flag_v} !== e) begin
      bad++; $display("FAIL add_scoreboard got=%h want=%h", {result, flag_z, flag_n, flag_c, flag_v}, e);
    end
    release_out();
  endtask

  task automatic test_sub;
    int lat;
    logic [11:0] e;
    send(3'd1, 8'h05, 8'h05, 3'd0);
    wait_out(lat);
    e = sb.pop_front();
    $display("txn SUB 05-05 lat=%0d res=%h zncv=%b%b%b%b", lat, result, flag_z, flag_n, flag_c, flag_v);
    total++;
    if ({result, flag_z, flag_n, flag_c, flag_v} !== {8'h00, 4'b1010} || e !== {8'h00, 4'b1010}) begin
      bad++; $display("FAIL sub_equal got=%h want=%h", {result, flag_z, flag_n, flag_c, flag_v}, {8'h00, 4'b1010});
    end
    release_out();
    send(3'd1, 8'h00, 8'h01, 3'd0);
    wait_out(lat);
    e = sb.pop_front();
    $display("txn SUB 00-01 lat=%0d res=%h zncv=%b%b%b%b", lat, result, flag_z, flag_n, flag_c, flag_v);
    total++;
    if ({result, flag_z, flag_n, flag_c, flag_v} !== {8'hFF, 4'b0100}) begin
      bad++; $display("FAIL sub_borrow got=%h want=%h", {result, flag_z, flag_n, flag_c, flag_v}, {8'hFF, 4'b0100});
    end
    release_out();
  endtask

  task automatic test_shift;
    int lat;
    bit busy_ok;
    logic [11:0] e;
    send(3'd7, 8'h90, 8'h00, 3'd3);
    lat = 1; busy_ok = 1'b1;
    while (!out_valid && lat < 64) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    e = sb.pop_front();
    $display("txn SRA 90>>>3 lat=%0d res=%h c=%b", lat, result, flag_c);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL sra_latency got=%0d want=4", lat); end
    total++;
    if (!busy_ok) begin bad++; $display("FAIL sra_busy got=0 want=1 throughout"); end
    total++;
    if ({result, flag_z, flag_n, flag_c, flag_v} !== e) begin
      bad++; $display("FAIL sra_result got=%h want=%h", {result, flag_z, flag_n, flag_c, flag_v}, e);
    end
    release_out();
    send(3'd5, 8'h81, 8'h00, 3'd1);
    wait_out(lat);
    e = sb.pop_front();
    $display("txn SLL 81<<1 lat=%0d res=%h c=%b", lat, result, flag_c);
    total++;
    if (lat !== 2 || {result, flag_c} !== {8'h02, 1'b1}) begin
      bad++; $display("FAIL sll_one got lat=%0d res=%h c=%b want lat=2 res=02 c=1", lat, result, flag_c);
    end
    total++;
    if ({result, flag_z, flag_n, flag_c, flag_v} !== e) begin
      bad++; $display("FAIL sll_scoreboard got=%h want=%h", {result, flag_z, flag_n, flag_c, flag_v}, e);
    end
    release_out();
  endtask

  task automatic test_random;
    int lat, want_lat;
    logic [11:0] e;
    logic [2:0] o, s;
    logic [7:0] x, y;
    for (int i = 0; i < 12; i++) begin
      o = 3'($urandom_range(0, 7)); s = 3'($urandom_range(0, 7));
      x = 8'($urandom); y = 8'($urandom);
      want_lat = (o >= 3'd5 && s != 3'd0) ? 1 + int'(s) : 1;
      send(o, x, y, s);
      wait_out(lat);
      e = sb.pop_front();
      $display("txn op=%0d a=%h b=%h s=%0d lat=%0d res=%h zncv=%b%b%b%b", o, x, y, s, lat,
               result, flag_z, flag_n, flag_c, flag_v);
      total++;
      if (lat !== want_lat || {result, flag_z, flag_n, flag_c, flag_v} !== e) begin
        bad++;
        $display("FAIL random_op got lat=%0d val=%h want lat=%0d val=%h", lat,
                 {result, flag_z, flag_n, flag_c, flag_v}, want_lat, e);
      end
      release_out();
    end
  endtask

  task automatic test_hold;
    int lat;
    bit hold_ok;
    logic [11:0] e;
    logic [7:0] cnt0;
    send(3'd6, 8'h3C, 8'h00, 3'd0);
    wait_out(lat);
    e = sb.pop_front();
    cnt0 = op_count;
    hold_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      op = 3'd0; a = 8'hAA; b = 8'h11; in_valid = (i % 2 == 0);
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          {result, flag_z, flag_n, flag_c, flag_v} !== e) hold_ok = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    $display("txn SRL 3c>>0 lat=%0d res=%h c=%b held", lat, result, flag_c);
    total++;
    if (lat !== 1 || {result, flag_c} !== {8'h3C, 1'b0}) begin
      bad++; $display("FAIL srl_zero got lat=%0d res=%h c=%b want lat=1 res=3c c=0", lat, result, flag_c);
    end
    total++;
    if (!hold_ok) begin bad++; $display("FAIL hold_stable got=unstable want=stable, ready=0"); end
    release_out();
    total++;
    if (op_count !== cnt0 + 8'd1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL hold_release got cnt=%0d busy=%b ov=%b want cnt=%0d busy=0 ov=0",
                      op_count, busy, out_valid, cnt0 + 8'd1);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    send(3'd5, 8'hFF, 8'h00, 3'd7);
    void'(sb.pop_back());
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    $display("txn SLL ff<<7 aborted by reset");
    total++;
    if ({out_valid, busy, op_count, result} !== 18'h0) begin
      bad++; $display("FAIL reset_mid got ov=%b busy=%b cnt=%0d res=%h want all 0",
                      out_valid, busy, op_count, result);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    send(3'd0, 8'h01, 8'h02, 3'd0);
    wait_out(lat);
    $display("txn ADD 01+02 lat=%0d res=%h", lat, result);
    total++;
    if (lat !== 1 || {result, flag_z, flag_n, flag_c, flag_v} !== sb.pop_front() || result !== 8'h03) begin
      bad++; $display("FAIL post_reset_add got lat=%0d res=%h want lat=1 res=03", lat, result);
    end
    release_out();
  endtask

  task automatic test_back_to_back;
    logic [7:0] q4[$];
    logic [7:0] e;
    int issued, done, cyc;
    bit acc, fin;
    issued = 0; done = 0; cyc = 0;
    op = 3'd2; a = 8'($urandom); b = 8'($urandom);
    in_valid4 = 1'b1; out_ready4 = 1'b1;
    while (done < 16 && cyc < 200) begin
      acc = in_valid4 && in_ready4;
      fin = out_valid4 && out_ready4;
      if (acc) begin q4.push_back(a & b); issued++; end
      if (fin) begin
        e = q4.pop_front();
        done++;
        $display("txn AND#%0d res=%h", done, result4);
        total++;
        if (result4 !== e || z4 !== (e == 8'h00)) begin
          bad++; $display("FAIL b2b_and got=%h z=%b want=%h", result4, z4, e);
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        a = 8'($urandom); b = 8'($urandom);
        if (issued == 16) in_valid4 = 1'b0;
      end
    end
    total++;
    if (done != 16 || op_count4 !== 4'd0) begin
      bad++; $display("FAIL count_wrap got done=%0d cnt=%0d want done=16 cnt=0", done, op_count4);
    end
    in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    total++;
    if (op_count4 !== 4'd1) begin
      bad++; $display("FAIL count_17th got=%0d want=1", op_count4);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_random();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
